fb_tx_sequencer: RTL and testbench
==================================

# fb_tx_sequencer

Transmit-frame state machine for the FREEDM bus master. It drives the one-hot state flags consumed by the tx nibble-counter block (`fb_txcounters`), and uses that block's end-of-field feedback to step a frame through its fields. The frame order is preamble, SoC, slave count, distance, delay, delay-distance, N slave data slots each followed by a slot CRC, then the frame CRC. It also provides the start/done/abort handshake to the frame-building logic and enforces a minimum inter-frame gap.

## Interface

- `IFG_NIB`, default 24: minimum number of Idle cycles between frames (range 1..255).
- `MTxClk` in 1: tx nibble clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `TxStartFrm` in 1: level request to start a frame; held until `TxStartAck`.
- `TxAbort` in 1: abort request; honoured in any non-Idle state.
- `SlaveCount` in 4: number of slave slots; sampled when the start is accepted; 0 is treated as 1.
- `SlotNibbles` in 16: data nibbles per slot; sampled when the start is accepted; bit 0 is ignored; 0 or 1 is treated as 2.
- `PreambleStateEnd`, `CrcStateEnd`, `FrmCrcStateEnd` in 1 each: end-of-field flags from the counter block.
- `NibCnt` in 16: per-slot data nibble count from the counter block.
- `StateIdle`, `StatePreamble`, `StateSoC`, `StateNumb`, `StateDelay`, `StateCrc`, `StateFrmCrc` out 1 each: state flags.
- `StateDist`, `StateDelayDist`, `StateData` out 2 each: two-nibble field flags; bit 0 is the low nibble, bit 1 the high nibble.
- `StartData` out 2: data-start strobes (defined under Operation).
- `SlotIdx` out 4: index of the current slave slot.
- `TxStartAck`, `TxDone`, `TxAborted` out 1 each: one-cycle handshake pulses.

## Operation

- The state register is one-hot. Exactly one flag among the State* outputs (counting each vector bit separately) is high at any time.
- State transitions:
  - Idle → Preamble when `TxStartFrm` is high and the gap is satisfied.
  - Preamble → SoC when `PreambleStateEnd` is high. The preamble lasts 3 cycles.
  - SoC → Numb → Dist[0] → Dist[1] → Delay → DelayDist[0] → DelayDist[1] → Data[0]. Each of these states lasts one cycle.
  - Data[0] → Data[1].
  - Data[1] → Crc when `NibCnt == SlotNibbles_latched - 1`; otherwise Data[1] → Data[0].
  - Crc → Data[0] when `CrcStateEnd` is high and `SlotIdx < SlaveCount_latched - 1`. In that case `SlotIdx` increments.
  - Crc → FrmCrc when `CrcStateEnd` is high and the last slot has been sent.
  - FrmCrc → Idle when `FrmCrcStateEnd` is high.
- `StartData[0]` is combinational and is high in the cycle before each Data[0] slot entry: DelayDist[1], or a Crc exit that leads to Data.
- `StartData[1]` equals `StateData[0]`.
- `SlotIdx` clears to 0 on start acceptance.
- `TxStartAck` is registered and high during the first Preamble cycle.
- `TxDone` is high during the first Idle cycle after a normal FrmCrc exit.
- Abort:
  - `TxAbort` high in any non-Idle state forces Idle on the next edge and pulses `TxAborted` in that first Idle cycle.
  - Abort takes priority over every other transition.
  - `TxDone` is not asserted after an abort.
- Gap counter:
  - 8 bits. Loads 0 on any entry to Idle and increments while Idle, saturating at `IFG_NIB`.
  - A start is accepted only when the counter equals `IFG_NIB`.
  - Reset sets the counter to `IFG_NIB`, so a start may be accepted immediately after reset.
- A `TxStartFrm` that arrives during a frame has no effect until Idle and the gap are both reached.

## Timing

- Reset values:
  - `StateIdle` = 1.
  - All other State* outputs = 0, `StartData` = 0.
  - `SlotIdx` = 0.
  - `TxStartAck` = `TxDone` = `TxAborted` = 0.
  - Latched configuration = 0.
- Start latency: `TxStartFrm` sampled high at edge k puts the block in Preamble from cycle k+1.
- Frame length from the first Preamble cycle to the last FrmCrc cycle, inclusive: 10 + N·(S+2) + 2 cycles, where N is the latched slave count and S is the latched slot nibble count.
- Reset asserted mid-frame returns the block to Idle asynchronously, with no `TxDone` or `TxAborted` pulse.
- Back-to-back frames: the earliest next Preamble is `IFG_NIB` + 1 cycles after the first Idle cycle.

## Configuration

- `FB_TXSEQ_IFG_EN`
  - Defined: the gap counter and the `IFG_NIB` gating operate as described above.
  - Undefined: the gap counter is removed and a start is accepted in any Idle cycle, including the `TxDone` or `TxAborted` cycle.

## Test plan

The bench closes the loop with `fb_txcounters`.

1. Reset, then `TxStartFrm` = 1 with `SlaveCount` = 2 and `SlotNibbles` = 4 → `TxStartAck` in the first Preamble cycle; Preamble lasts 3 cycles; 24 cycles from the first Preamble cycle to the last FrmCrc cycle; `SlotIdx` is 0 then 1; `TxDone` pulses once.
2. `SlaveCount` = 0 and `SlotNibbles` = 1 → the frame runs as 1 slot of 2 data nibbles; total length 16 cycles.
3. `TxAbort` pulsed during the second Data[1] cycle of slot 0 → Idle on the next cycle, `TxAborted` = 1, no `TxDone`; a held `TxStartFrm` restarts after exactly `IFG_NIB` + 1 cycles.
4. `TxStartFrm` held high continuously with `IFG_NIB` = 24 → 25 cycles from the first Idle cycle to the next Preamble. With the macro undefined, the next Preamble is 1 cycle after FrmCrc ends.
5. `Reset` asserted asynchronously mid-Crc → all outputs return to their reset values immediately; the next start is accepted at the first edge after release.
6. Every cycle of the above scenarios: the State* flags are one-hot, and `StartData[0]` is high only in the cycle before each Data[0] slot entry.

Source files
------------

// File: rtl/fb_tx_sequencer.sv
// rtl/fb_tx_sequencer.sv - FREEDM bus master transmit-frame sequencer
//
// Purpose: one-hot frame state machine that steps a tx frame through
//   preamble, SoC, slave count, distance, delay, delay-distance, N slave
//   slots (data + slot CRC) and the frame CRC. It drives the state flags
//   used by the tx nibble counters and follows their end-of-field feedback.
//   It also provides the start/done/abort handshake and an inter-frame gap.
//
// Build option: FB_TXSEQ_IFG_EN
//   defined   - an 8-bit gap counter holds off a new start until IFG_NIB Idle
//               cycles have passed
//   undefined - a start is accepted in any Idle cycle
//
// Parameters:
//   IFG_NIB           minimum Idle cycles between frames (1..255)
// Ports:
//   MTxClk            tx nibble clock
//   Reset             asynchronous active-high reset
//   TxStartFrm        start request level, held until TxStartAck
//   TxAbort           abort request, honoured in any non-Idle state
//   SlaveCount[3:0]   slave slots per frame, 0 means 1 (latched at start)
//   SlotNibbles[15:0] data nibbles per slot, bit 0 ignored, 0/1 means 2
//   PreambleStateEnd  last preamble cycle
//   CrcStateEnd       last slot CRC cycle
//   FrmCrcStateEnd    last frame CRC cycle
//   NibCnt[15:0]      data nibble count within the current slot
//   State*            one-hot state flags; the 2-bit ones are low/high nibble
//   StartData[1:0]    [0] cycle before each slot's Data[0], [1] = StateData[0]
//   SlotIdx[3:0]      current slave slot
//   TxStartAck        first Preamble cycle
//   TxDone            first Idle cycle after a completed frame
//   TxAborted         first Idle cycle after an abort

module fb_tx_sequencer #(
   parameter int IFG_NIB = 24
) (
   input  logic        MTxClk,
   input  logic        Reset,
   input  logic        TxStartFrm,
   input  logic        TxAbort,
   input  logic [3:0]  SlaveCount,
   input  logic [15:0] SlotNibbles,
   input  logic        PreambleStateEnd,
   input  logic        CrcStateEnd,
   input  logic        FrmCrcStateEnd,
   input  logic [15:0] NibCnt,
   output logic        StateIdle,
   output logic        StatePreamble,
   output logic        StateSoC,
   output logic        StateNumb,
   output logic [1:0]  StateDist,
   output logic        StateDelay,
   output logic [1:0]  StateDelayDist,
   output logic [1:0]  StateData,
   output logic        StateCrc,
   output logic        StateFrmCrc,
   output logic [1:0]  StartData,
   output logic [3:0]  SlotIdx,
   output logic        TxStartAck,
   output logic        TxDone,
   output logic        TxAborted
);

   localparam int S_IDLE   = 0;
   localparam int S_PRE    = 1;
   localparam int S_SOC    = 2;
   localparam int S_NUMB   = 3;
   localparam int S_DIST0  = 4;
   localparam int S_DIST1  = 5;
   localparam int S_DELAY  = 6;
   localparam int S_DD0    = 7;
   localparam int S_DD1    = 8;
   localparam int S_DATA0  = 9;
   localparam int S_DATA1  = 10;
   localparam int S_CRC    = 11;
   localparam int S_FCRC   = 12;
   localparam int NST      = 13;

   localparam logic [NST-1:0] IDLE_VEC = {{(NST-1){1'b0}}, 1'b1};

   logic [NST-1:0] state;
   logic [NST-1:0] nextState;
   logic [3:0]     slaveCountLat;
   logic [15:0]    slotNibLat;
   logic [3:0]     slaveCountEff;
   logic [15:0]    slotNibEven;
   logic [15:0]    slotNibEff;
   logic           gapOk;
   logic           startAccept;
   logic           lastSlot;
   logic           lastNib;
   logic           crcToData;
   logic           abortReq;

   // Normalise configuration at the moment it is latched so the running
   // frame never sees a zero slot count or an odd/short slot.
   always_comb begin
      slaveCountEff = (SlaveCount == 4'd0) ? 4'd1 : SlaveCount;
      slotNibEven   = SlotNibbles & 16'hFFFE;
      slotNibEff    = (slotNibEven == 16'd0) ? 16'd2 : slotNibEven;
   end

   assign abortReq    = ~state[S_IDLE] & TxAbort;
   assign startAccept = state[S_IDLE] & TxStartFrm & gapOk;
   assign lastSlot    = (SlotIdx == slaveCountLat - 4'd1);
   assign lastNib     = (NibCnt == slotNibLat - 16'd1);
   assign crcToData   = state[S_CRC] & CrcStateEnd & ~lastSlot;

`ifdef FB_TXSEQ_IFG_EN
   localparam logic [7:0] IFG_VAL = IFG_NIB[7:0];

   logic [7:0] gapCnt;

   // Starts from IFG_VAL after reset so the first frame needs no gap.
   always_ff @(posedge MTxClk or posedge Reset) begin
      if (Reset) begin
         gapCnt <= IFG_VAL;
      end else if (~state[S_IDLE] & nextState[S_IDLE]) begin
         gapCnt <= 8'd0;
      end else if (state[S_IDLE] && (gapCnt != IFG_VAL)) begin
         gapCnt <= gapCnt + 8'd1;
      end
   end

   assign gapOk = (gapCnt == IFG_VAL);
`else
   assign gapOk = 1'b1;
`endif

   // State register
   always_ff @(posedge MTxClk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE_VEC;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; abort outranks every field transition.
   always_comb begin
      nextState = '0;
      if (state[S_IDLE]) begin
         if (startAccept) nextState[S_PRE]  = 1'b1;
         else             nextState[S_IDLE] = 1'b1;
      end else if (TxAbort) begin
         nextState[S_IDLE] = 1'b1;
      end else if (state[S_PRE]) begin
         if (PreambleStateEnd) nextState[S_SOC] = 1'b1;
         else                  nextState[S_PRE] = 1'b1;
      end else if (state[S_SOC]) begin
         nextState[S_NUMB] = 1'b1;
      end else if (state[S_NUMB]) begin
         nextState[S_DIST0] = 1'b1;
      end else if (state[S_DIST0]) begin
         nextState[S_DIST1] = 1'b1;
      end else if (state[S_DIST1]) begin
         nextState[S_DELAY] = 1'b1;
      end else if (state[S_DELAY]) begin
         nextState[S_DD0] = 1'b1;
      end else if (state[S_DD0]) begin
         nextState[S_DD1] = 1'b1;
      end else if (state[S_DD1]) begin
         nextState[S_DATA0] = 1'b1;
      end else if (state[S_DATA0]) begin
         nextState[S_DATA1] = 1'b1;
      end else if (state[S_DATA1]) begin
         if (lastNib) nextState[S_CRC]   = 1'b1;
         else         nextState[S_DATA0] = 1'b1;
      end else if (state[S_CRC]) begin
         if (!CrcStateEnd)  nextState[S_CRC]   = 1'b1;
         else if (lastSlot) nextState[S_FCRC]  = 1'b1;
         else               nextState[S_DATA0] = 1'b1;
      end else if (state[S_FCRC]) begin
         if (FrmCrcStateEnd) nextState[S_IDLE] = 1'b1;
         else                nextState[S_FCRC] = 1'b1;
      end else begin
         // Not a legal one-hot code: fall back to Idle.
         nextState[S_IDLE] = 1'b1;
      end
   end

   // Output decode
   always_comb begin
      StateIdle      = state[S_IDLE];
      StatePreamble  = state[S_PRE];
      StateSoC       = state[S_SOC];
      StateNumb      = state[S_NUMB];
      StateDist      = {state[S_DIST1], state[S_DIST0]};
      StateDelay     = state[S_DELAY];
      StateDelayDist = {state[S_DD1], state[S_DD0]};
      StateData      = {state[S_DATA1], state[S_DATA0]};
      StateCrc       = state[S_CRC];
      StateFrmCrc    = state[S_FCRC];
      StartData      = {state[S_DATA0], state[S_DD1] | crcToData};
   end

   // Latched configuration, slot index and handshake pulses
   always_ff @(posedge MTxClk or posedge Reset) begin
      if (Reset) begin
         slaveCountLat <= 4'd0;
         slotNibLat    <= 16'd0;
         SlotIdx       <= 4'd0;
         TxStartAck    <= 1'b0;
         TxDone        <= 1'b0;
         TxAborted     <= 1'b0;
      end else begin
         TxStartAck <= startAccept;
         TxDone     <= state[S_FCRC] & FrmCrcStateEnd & ~TxAbort;
         TxAborted  <= abortReq;
         if (startAccept) begin
            slaveCountLat <= slaveCountEff;
            slotNibLat    <= slotNibEff;
            SlotIdx       <= 4'd0;
         end else if (crcToData & ~TxAbort) begin
            SlotIdx <= SlotIdx + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_fb_tx_sequencer.sv
// tb/tb_fb_tx_sequencer.sv - self-checking bench for fb_tx_sequencer
//
// Purpose: closes the loop with a behavioural stand-in for the tx nibble
//   counters and checks the sequencer every cycle against a frame-level
//   model (expected field list per frame), plus directed literal checks.
// Ports: none (top-level bench).

module tb_fb_tx_sequencer;

   localparam int IFG = 24;
`ifdef FB_TXSEQ_IFG_EN
   localparam int EXP_GAP = IFG + 1;
`else
   localparam int EXP_GAP = 1;
`endif

   // Field labels used by the model
   localparam int F_IDLE = 0, F_PRE = 1, F_SOC = 2, F_NUMB = 3, F_DIST0 = 4,
                  F_DIST1 = 5, F_DELAY = 6, F_DD0 = 7, F_DD1 = 8, F_DATA0 = 9,
                  F_DATA1 = 10, F_CRC = 11, F_FCRC = 12;

   logic        MTxClk;
   logic        Reset;
   logic        TxStartFrm;
   logic        TxAbort;
   logic [3:0]  SlaveCount;
   logic [15:0] SlotNibbles;
   logic        PreambleStateEnd;
   logic        CrcStateEnd;
   logic        FrmCrcStateEnd;
   logic [15:0] NibCnt;
   logic        StateIdle;
   logic        StatePreamble;
   logic        StateSoC;
   logic        StateNumb;
   logic [1:0]  StateDist;
   logic        StateDelay;
   logic [1:0]  StateDelayDist;
   logic [1:0]  StateData;
   logic        StateCrc;
   logic        StateFrmCrc;
   logic [1:0]  StartData;
   logic [3:0]  SlotIdx;
   logic        TxStartAck;
   logic        TxDone;
   logic        TxAborted;

   int checks = 0;
   int errors = 0;

   fb_tx_sequencer #(.IFG_NIB(IFG)) dut (
      .MTxClk(MTxClk),
      .Reset(Reset),
      .TxStartFrm(TxStartFrm),
      .TxAbort(TxAbort),
      .SlaveCount(SlaveCount),
      .SlotNibbles(SlotNibbles),
      .PreambleStateEnd(PreambleStateEnd),
      .CrcStateEnd(CrcStateEnd),
      .FrmCrcStateEnd(FrmCrcStateEnd),
      .NibCnt(NibCnt),
      .StateIdle(StateIdle),
      .StatePreamble(StatePreamble),
      .StateSoC(StateSoC),
      .StateNumb(StateNumb),
      .StateDist(StateDist),
      .StateDelay(StateDelay),
      .StateDelayDist(StateDelayDist),
      .StateData(StateData),
      .StateCrc(StateCrc),
      .StateFrmCrc(StateFrmCrc),
      .StartData(StartData),
      .SlotIdx(SlotIdx),
      .TxStartAck(TxStartAck),
      .TxDone(TxDone),
      .TxAborted(TxAborted)
   );

   initial MTxClk = 1'b0;
   always #5 MTxClk = ~MTxClk;

   // Stand-in for fb_txcounters: preamble 3 cycles, slot CRC 2, frame CRC 2,
   // NibCnt counts data nibbles within a slot.
   logic [1:0]  preCnt, crcCnt, fcCnt;
   logic [15:0] nib;

   always @(posedge MTxClk or posedge Reset) begin
      if (Reset) begin
         preCnt <= 2'd0;
         crcCnt <= 2'd0;
         fcCnt  <= 2'd0;
         nib    <= 16'd0;
      end else begin
         preCnt <= StatePreamble ? preCnt + 2'd1 : 2'd0;
         crcCnt <= StateCrc ? crcCnt + 2'd1 : 2'd0;
         fcCnt  <= StateFrmCrc ? fcCnt + 2'd1 : 2'd0;
         nib    <= (StateData != 2'b00) ? nib + 16'd1 : 16'd0;
      end
   end

   assign PreambleStateEnd = StatePreamble && (preCnt == 2'd2);
   assign CrcStateEnd      = StateCrc && (crcCnt == 2'd1);
   assign FrmCrcStateEnd   = StateFrmCrc && (fcCnt == 2'd1);
   assign NibCnt           = nib;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [12:0] dutVec();
      return {StateFrmCrc, StateCrc, StateData[1], StateData[0],
              StateDelayDist[1], StateDelayDist[0], StateDelay,
              StateDist[1], StateDist[0], StateNumb, StateSoC,
              StatePreamble, StateIdle};
   endfunction

   // Frame-level model: a queue of the remaining (field, slot) cycles.
   typedef struct {
      int idx;
      int slot;
   } ent_t;

   ent_t q[$];
   int   curIdx, curSlot, idleCnt;
   bit   curAck, curDone, curAbt;

   function automatic void pushEnt(input int idx, input int slot);
      ent_t e;
      e.idx  = idx;
      e.slot = slot;
      q.push_back(e);
   endfunction

   function automatic void buildFrame(input int n, input int s);
      int effN, effS;
      effN = (n == 0) ? 1 : n;
      effS = s - (s % 2);
      if (effS == 0) effS = 2;
      q.delete();
      for (int i = 0; i < 3; i++) pushEnt(F_PRE, 0);
      pushEnt(F_SOC, 0);
      pushEnt(F_NUMB, 0);
      pushEnt(F_DIST0, 0);
      pushEnt(F_DIST1, 0);
      pushEnt(F_DELAY, 0);
      pushEnt(F_DD0, 0);
      pushEnt(F_DD1, 0);
      for (int k = 0; k < effN; k++) begin
         for (int j = 0; j < effS; j++) pushEnt((j % 2 == 1) ? F_DATA1 : F_DATA0, k);
         pushEnt(F_CRC, k);
         pushEnt(F_CRC, k);
      end
      pushEnt(F_FCRC, effN - 1);
      pushEnt(F_FCRC, effN - 1);
   endfunction

   initial begin
      ent_t e;
      bit   gapOk, expSd0;
      forever begin
         @(negedge MTxClk);
         if (Reset) begin
            q.delete();
            curIdx  = F_IDLE;
            curSlot = 0;
            curAck  = 0;
            curDone = 0;
            curAbt  = 0;
            idleCnt = IFG;
         end
         expSd0 = (curIdx == F_DD1) ||
                  (curIdx == F_CRC && q.size() > 0 && q[0].idx == F_DATA0);
         chk("state", 32'(dutVec()), 32'(1) << curIdx);
         chk("onehot", 32'($countones(dutVec())), 32'd1);
         chk("slot_idx", 32'(SlotIdx), 32'(curSlot));
         chk("start_ack", 32'(TxStartAck), 32'(curAck));
         chk("tx_done", 32'(TxDone), 32'(curDone));
         chk("tx_aborted", 32'(TxAborted), 32'(curAbt));
         chk("start_data0", 32'(StartData[0]), 32'(expSd0));
         chk("start_data1", 32'(StartData[1]), 32'(curIdx == F_DATA0));
         if (!Reset) begin
            curAck  = 0;
            curDone = 0;
            curAbt  = 0;
            if (curIdx == F_IDLE) begin
`ifdef FB_TXSEQ_IFG_EN
               gapOk = (idleCnt == IFG);
`else
               gapOk = 1'b1;
`endif
               if (TxStartFrm && gapOk) begin
                  buildFrame(int'(SlaveCount), int'(SlotNibbles));
                  e       = q.pop_front();
                  curIdx  = e.idx;
                  curSlot = e.slot;
                  curAck  = 1;
               end else if (idleCnt < IFG) begin
                  idleCnt++;
               end
            end else if (TxAbort) begin
               q.delete();
               curIdx  = F_IDLE;
               curAbt  = 1;
               idleCnt = 0;
            end else if (q.size() == 0) begin
               curIdx  = F_IDLE;
               curDone = 1;
               idleCnt = 0;
            end else begin
               e       = q.pop_front();
               curIdx  = e.idx;
               curSlot = e.slot;
            end
         end
      end
   end

   task automatic tick();
      @(posedge MTxClk);
      #1;
   endtask

   // Called in the first Preamble cycle; returns in the first Idle cycle.
   task automatic runFrame(output int len, output int pre, output int maxSlot,
                           output bit done, output bit aborted);
      len = 0;
      pre = 0;
      maxSlot = 0;
      for (int i = 0; i < 400 && !StateIdle; i++) begin
         len++;
         if (StatePreamble) pre++;
         if (int'(SlotIdx) > maxSlot) maxSlot = int'(SlotIdx);
         tick();
      end
      chk("frame_timeout", 32'(StateIdle), 32'd1);
      done    = TxDone;
      aborted = TxAborted;
   endtask

   // Called in the first Idle cycle; returns in the next Preamble cycle.
   task automatic measureGap(output int g);
      g = 0;
      while (!StatePreamble && g < 100) begin
         tick();
         g++;
      end
      chk("gap_timeout", 32'(StatePreamble), 32'd1);
   endtask

   initial begin
      int len, pre, maxSlot, gap, seen, guard;
      bit done, aborted;

      Reset       = 1'b1;
      TxStartFrm  = 1'b0;
      TxAbort     = 1'b0;
      SlaveCount  = 4'd0;
      SlotNibbles = 16'd0;
      #1;
      chk("reset_idle", 32'(StateIdle), 32'd1);
      chk("reset_flags", 32'(dutVec()), 32'd1);
      chk("reset_startdata", 32'(StartData), 32'd0);
      repeat (3) tick();

      // 1: two slots of four nibbles
      Reset       = 1'b0;
      SlaveCount  = 4'd2;
      SlotNibbles = 16'd4;
      TxStartFrm  = 1'b1;
      tick();
      chk("s1_preamble", 32'(StatePreamble), 32'd1);
      chk("s1_ack", 32'(TxStartAck), 32'd1);
      TxStartFrm = 1'b0;
      runFrame(len, pre, maxSlot, done, aborted);
      chk("s1_len", 32'(len), 32'd24);
      chk("s1_pre_len", 32'(pre), 32'd3);
      chk("s1_max_slot", 32'(maxSlot), 32'd1);
      chk("s1_done", 32'(done), 32'd1);
      chk("s1_aborted", 32'(aborted), 32'd0);
      repeat (30) tick();

      // 2: zero slave count and one nibble normalise to 1 x 2
      SlaveCount  = 4'd0;
      SlotNibbles = 16'd1;
      TxStartFrm  = 1'b1;
      tick();
      chk("s2_preamble", 32'(StatePreamble), 32'd1);
      TxStartFrm = 1'b0;
      runFrame(len, pre, maxSlot, done, aborted);
      chk("s2_len", 32'(len), 32'd16);
      chk("s2_max_slot", 32'(maxSlot), 32'd0);
      chk("s2_done", 32'(done), 32'd1);
      repeat (30) tick();

      // 3: abort in the second Data[1] cycle of slot 0, start held
      SlaveCount  = 4'd2;
      SlotNibbles = 16'd4;
      TxStartFrm  = 1'b1;
      tick();
      chk("s3_preamble", 32'(StatePreamble), 32'd1);
      seen  = 0;
      guard = 0;
      while (guard < 50) begin
         if (StateData[1]) begin
            seen++;
            if (seen == 2) break;
         end
         tick();
         guard++;
      end
      chk("s3_abort_point", 32'(seen), 32'd2);
      chk("s3_abort_slot", 32'(SlotIdx), 32'd0);
      TxAbort = 1'b1;
      tick();
      TxAbort = 1'b0;
      chk("s3_idle", 32'(StateIdle), 32'd1);
      chk("s3_aborted", 32'(TxAborted), 32'd1);
      chk("s3_no_done", 32'(TxDone), 32'd0);
      measureGap(gap);
      chk("s3_gap", 32'(gap), 32'(EXP_GAP));

      // 4: start held continuously across a completed frame
      chk("s4_ack", 32'(TxStartAck), 32'd1);
      runFrame(len, pre, maxSlot, done, aborted);
      chk("s4_len", 32'(len), 32'd24);
      chk("s4_done", 32'(done), 32'd1);
      measureGap(gap);
      chk("s4_gap", 32'(gap), 32'(EXP_GAP));
      TxStartFrm = 1'b0;

      // 5: asynchronous reset in the middle of a slot CRC
      guard = 0;
      while (!StateCrc && guard < 50) begin
         tick();
         guard++;
      end
      chk("s5_reach_crc", 32'(StateCrc), 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      chk("s5_async_flags", 32'(dutVec()), 32'd1);
      chk("s5_async_slot", 32'(SlotIdx), 32'd0);
      chk("s5_async_pulses", 32'({TxStartAck, TxDone, TxAborted}), 32'd0);
      chk("s5_async_sd", 32'(StartData), 32'd0);
      tick();
      Reset      = 1'b0;
      TxStartFrm = 1'b1;
      tick();
      chk("s5_restart", 32'(StatePreamble), 32'd1);
      chk("s5_restart_ack", 32'(TxStartAck), 32'd1);
      TxStartFrm = 1'b0;
      runFrame(len, pre, maxSlot, done, aborted);
      chk("s5_len", 32'(len), 32'd24);
      chk("s5_done", 32'(done), 32'd1);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
